instr_cmd_bridge: RTL and testbench

- Parametrised successor to the single-word HPS instruction PIO path.
- Captures the instruction word on each rising edge of the HPS enable PIO and buffers words in a FIFO of depth DEPTH.
- Issues each word to the FPGA datapath (zoom/image core) over a valid/ready handshake and waits for a completion pulse.
- Returns busy/fill/error/completion status to the HPS on a 32-bit status word, so software no longer has to poll-and-wait per instruction.

---
 rtl/instr_cmd_bridge_pkg.sv | 24 ++
 rtl/instr_sync_fifo.sv | 55 +++++
 rtl/instr_cmd_bridge.sv | 183 ++++++++++++++++++
 tb/tb_instr_cmd_bridge.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cmd_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_cmd_bridge_pkg
// Description : Shared FSM state type and status-word bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_cmd_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int ST_BUSY     = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_EMPTY    = 2;
    localparam int ST_OVF      = 3;
    localparam int ST_TMO      = 4;
    localparam int ST_CNT_LSB  = 8;
    localparam int ST_DONE_LSB = 16;

endpackage
`default_nettype wire

// File: rtl/instr_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_sync_fifo
// Description : Single-clock show-ahead FIFO; wrap-bit pointers, push accepted
//               when full only if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_do_pop;
    logic              w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign dout      = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/instr_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : instr_cmd_bridge
// Description : Buffers HPS PIO instruction words and issues them to the
//               datapath over valid/ready, tracking completion and status.
//               Optional watchdog: define INSTR_CMD_BRIDGE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_cmd_bridge
    import instr_cmd_bridge_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int OPC_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              instr_en,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DATA_W-1:0] cmd_data,
    output logic [OPC_W-1:0]  cmd_opcode,
    input  logic              done_in,
    input  logic              clr_status,
    output logic [31:0]       status_out
);

    localparam int c_CW = $clog2(DEPTH) + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_en_q;
    logic              w_rise;
    logic              w_pop;
    logic              w_done_evt;
    logic              w_tmo_evt;
    logic              w_wd_expired;
    logic              w_tmo_sticky;
    logic              w_ovf_evt;
    logic              r_ovf;
    logic [15:0]       r_completed;
    logic [DATA_W-1:0] r_cmd_data;
    logic [DATA_W-1:0] w_dout;
    logic [c_CW-1:0]   w_count;
    logic [7:0]        w_cnt8;
    logic              w_full;
    logic              w_empty;

    // Previous level resets high so an enable already asserted at reset is not a rise.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_en_q <= 1'b1;
        else             r_en_q <= instr_en;
    end

    assign w_rise    = instr_en & ~r_en_q;
    assign w_ovf_evt = w_rise & w_full & ~w_pop;

    instr_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (w_rise),
        .pop   (w_pop),
        .din   (instr_in),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_state <= IDLE;
        else             r_state <= w_state_nxt;
    end

    // Handshake and completion take priority over a coincident watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done_evt  = 1'b0;
        w_tmo_evt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    w_state_nxt = WAIT_DONE;
                end else if (w_wd_expired) begin
                    w_tmo_evt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (done_in) begin
                    w_done_evt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_wd_expired) begin
                    w_tmo_evt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset)  r_cmd_data <= '0;
        else if (w_pop)   r_cmd_data <= w_dout;
    end

    assign cmd_valid  = (r_state == ISSUE);
    assign cmd_data   = r_cmd_data;
    assign cmd_opcode = r_cmd_data[DATA_W-1 -: OPC_W];

`ifdef INSTR_CMD_BRIDGE_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_WD_W-1:0] r_wd;
    logic              r_tmo;

    always_ff @(posedge clk_clk) begin
        if (reset_reset || r_state == IDLE || w_state_nxt != r_state) r_wd <= '0;
        else                                                          r_wd <= r_wd + 1'b1;
    end

    assign w_wd_expired = (r_state != IDLE) && (r_wd == c_WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_clk) begin
        if (reset_reset)     r_tmo <= 1'b0;
        else if (w_tmo_evt)  r_tmo <= 1'b1;
        else if (clr_status) r_tmo <= 1'b0;
    end

    assign w_tmo_sticky = r_tmo;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC != 0);
    assign w_wd_expired = 1'b0;
    assign w_tmo_sticky = 1'b0;
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset)     r_ovf <= 1'b0;
        else if (w_ovf_evt)  r_ovf <= 1'b1;
        else if (clr_status) r_ovf <= 1'b0;
    end

    // A completion coinciding with a clear is counted after the clear.
    always_ff @(posedge clk_clk) begin
        if (reset_reset)     r_completed <= '0;
        else if (w_done_evt) r_completed <= clr_status ? 16'd1 : r_completed + 16'd1;
        else if (clr_status) r_completed <= '0;
    end

    generate
        if (DEPTH == 256) begin : g_cnt_sat
            assign w_cnt8 = w_count[c_CW-1] ? 8'hFF : w_count[7:0];
        end else begin : g_cnt_ext
            assign w_cnt8 = 8'(w_count);
        end
    endgenerate

    always_comb begin
        status_out                      = '0;
        status_out[ST_BUSY]             = (r_state != IDLE);
        status_out[ST_FULL]             = w_full;
        status_out[ST_EMPTY]            = w_empty;
        status_out[ST_OVF]              = r_ovf;
        status_out[ST_TMO]              = w_tmo_sticky;
        status_out[ST_CNT_LSB +: 8]     = w_cnt8;
        status_out[ST_DONE_LSB +: 16]   = r_completed;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_cmd_bridge
// Description : Scoreboard bench for instr_cmd_bridge with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_cmd_bridge;

    localparam int TB_TMO = 64;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [31:0] instr_in;
    logic        instr_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_opcode;
    logic        done_in;
    logic        clr_status;
    logic [31:0] status_out;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    int          exp_done = 0;
    logic [31:0] sb [$];

    instr_cmd_bridge #(
        .DATA_W      (32),
        .DEPTH       (8),
        .OPC_W       (4),
        .TIMEOUT_CYC (TB_TMO)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .instr_in    (instr_in),
        .instr_en    (instr_en),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .cmd_opcode  (cmd_opcode),
        .done_in     (done_in),
        .clr_status  (clr_status),
        .status_out  (status_out)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_issue);
        instr_in = w;
        instr_en = 1'b1;
        tick();
        instr_en = 1'b0;
        tick();
        if (expect_issue) sb.push_back(w);
    endtask

    task automatic pulse_done();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        exp_done++;
    endtask

    task automatic wait_valid(input string name, input int bound);
        int k;
        k = 0;
        while (!cmd_valid && k < bound) begin
            tick();
            k++;
        end
        if (!cmd_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: cmd_valid actual=0 required=1 within %0d cycles", name, bound);
        end
    endtask

    // Issue, accept and complete one queued command per call.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            wait_valid("drain_valid", 20);
            tick();
            pulse_done();
        end
    endtask

    // Monitor: checks every accepted command against the scoreboard.
    logic        stall_prev = 1'b0;
    logic [31:0] held_data  = '0;
    always @(negedge clk_clk) begin
        if (!reset_reset && cmd_valid) begin
            if (stall_prev) chk("hold_data", cmd_data, held_data);
            if (cmd_ready) begin
                n_xfer++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: actual=0x%0h required=none", cmd_data);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    chk("cmd_data", cmd_data, e);
                    chk("cmd_opcode", {28'd0, cmd_opcode}, {28'd0, e[31:28]});
                end
            end
            stall_prev = !cmd_ready;
            held_data  = cmd_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int x0;
        reset_reset = 1'b1;
        instr_in    = '0;
        instr_en    = 1'b0;
        cmd_ready   = 1'b0;
        done_in     = 1'b0;
        clr_status  = 1'b0;
        repeat (3) tick();
        reset_reset = 1'b0;
        tick();

        chk("reset_status", status_out, 32'h0000_0004);
        chk("reset_valid", {31'd0, cmd_valid}, 32'd0);
        chk("reset_data", cmd_data, 32'd0);
        chk("reset_opcode", {28'd0, cmd_opcode}, 32'd0);

        // Basic path and latency
        cmd_ready = 1'b1;
        instr_in  = 32'h3000_00AB;
        instr_en  = 1'b1;
        sb.push_back(32'h3000_00AB);
        tick();
        chk("lat_n1_valid", {31'd0, cmd_valid}, 32'd0);
        tick();
        chk("lat_n2_valid", {31'd0, cmd_valid}, 32'd1);
        instr_en = 1'b0;
        tick();
        chk("wait_busy", {31'd0, status_out[0]}, 32'd1);
        chk("wait_valid_low", {31'd0, cmd_valid}, 32'd0);
        pulse_done();
        chk("basic_completed", {16'd0, status_out[31:16]}, 32'd1);
        chk("basic_idle", {31'd0, status_out[0]}, 32'd0);

        // Backpressure
        cmd_ready = 1'b0;
        push_word(32'h5123_4567, 1'b1);
        wait_valid("bp_valid", 10);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid_hold", {31'd0, cmd_valid}, 32'd1);
            chk("bp_data_hold", cmd_data, 32'h5123_4567);
            tick();
        end
        x0 = n_xfer;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("bp_one_xfer", n_xfer - x0, 32'd1);
        chk("bp_valid_drop", {31'd0, cmd_valid}, 32'd0);
        pulse_done();

        // Overflow: one command stalled in ISSUE, then nine rises
        push_word(32'h1000_0000, 1'b1);
        for (int i = 1; i <= 9; i++)
            push_word(32'hA000_0000 + i, i <= 8);
        chk("ovf_full", {31'd0, status_out[1]}, 32'd1);
        chk("ovf_count", {24'd0, status_out[15:8]}, 32'd8);
        chk("ovf_flag", {31'd0, status_out[3]}, 32'd1);
        chk("ovf_completed", {16'd0, status_out[31:16]}, 32'd2);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        exp_done = 0;
        chk("ovf_clr", {31'd0, status_out[3]}, 32'd0);
        chk("ovf_clr_completed", {16'd0, status_out[31:16]}, 32'd0);
        chk("ovf_still_full", {31'd0, status_out[1]}, 32'd1);
        cmd_ready = 1'b1;
        drain(9);
        chk("ovf_drained_empty", {31'd0, status_out[2]}, 32'd1);
        chk("ovf_drained_completed", {16'd0, status_out[31:16]}, 32'd9);

        // Full with simultaneous push and pop
        push_word(32'h2000_0001, 1'b1);
        tick();
        cmd_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            push_word(32'hB000_0000 + i, 1'b1);
        chk("pp_full_count", {24'd0, status_out[15:8]}, 32'd8);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        exp_done++;
        instr_in = 32'hC000_00CC;
        instr_en = 1'b1;
        sb.push_back(32'hC000_00CC);
        tick();
        instr_en = 1'b0;
        chk("pp_count_same", {24'd0, status_out[15:8]}, 32'd8);
        chk("pp_no_ovf", {31'd0, status_out[3]}, 32'd0);
        chk("pp_busy", {31'd0, status_out[0]}, 32'd1);
        cmd_ready = 1'b1;
        drain(9);

        // Level hold: one push for a long high level
        x0 = n_xfer;
        instr_in = 32'h4000_0044;
        instr_en = 1'b1;
        sb.push_back(32'h4000_0044);
        repeat (50) tick();
        pulse_done();
        tick();
        chk("hold_one_xfer", n_xfer - x0, 32'd1);
        chk("hold_empty", {31'd0, status_out[2]}, 32'd1);

        // Enable high through reset release
        reset_reset = 1'b1;
        repeat (2) tick();
        reset_reset = 1'b0;
        exp_done = 0;
        x0 = n_xfer;
        repeat (10) tick();
        chk("rst_hold_status", status_out, 32'h0000_0004);
        chk("rst_hold_no_xfer", n_xfer - x0, 32'd0);
        instr_en = 1'b0;
        tick();

        // Reset mid-operation
        cmd_ready = 1'b0;
        push_word(32'h6000_0001, 1'b1);
        push_word(32'h6000_0002, 1'b1);
        chk("midrst_valid_pre", {31'd0, cmd_valid}, 32'd1);
        reset_reset = 1'b1;
        tick();
        sb.delete();
        chk("midrst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("midrst_status", status_out, 32'h0000_0004);
        reset_reset = 1'b0;
        tick();

        // Watchdog
        push_word(32'h7000_0001, 1'b1);
        push_word(32'h7000_0002, 1'b1);
        cmd_ready = 1'b1;
        tick();
`ifdef INSTR_CMD_BRIDGE_TIMEOUT_EN
        for (int i = 0; i < TB_TMO - 1; i++) tick();
        chk("tmo_busy_before", {31'd0, status_out[0]}, 32'd1);
        tick();
        chk("tmo_flag", {31'd0, status_out[4]}, 32'd1);
        chk("tmo_idle", {31'd0, status_out[0]}, 32'd0);
`else
        repeat (40) tick();
        chk("notmo_busy", {31'd0, status_out[0]}, 32'd1);
        chk("notmo_flag", {31'd0, status_out[4]}, 32'd0);
        pulse_done();
`endif
        drain(1);
        tick();

        chk("final_completed", {16'd0, status_out[31:16]}, exp_done);
        chk("final_sb_empty", sb.size(), 32'd0);
        chk("final_idle", {31'd0, status_out[0]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
